// File: rtl/cascade_counter.sv
// cascade_counter: N-stage cascaded modulo counter with per-stage moduli.
// It is typically used as a sec/min/hr timebase behind a prescaler enable.
//
// Features: up/down counting, saturating parallel load, per-stage terminal
// ticks, and a registered alarm comparator.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   count enable for stage 0 (one step per cycle)
//   up        in   1 = count up, 0 = count down
//   load      in   parallel load strobe (wins over counting)
//   load_val  in   N*DW load value, stage i at [i*DW +: DW]
//   alarm_en  in   alarm comparator enable
//   alarm_val in   N*DW alarm compare value, same layout as load_val
//   cnt       out  N*DW registered count
//   tick      out  N    combinational per-stage terminal-step flags
//   co        out  1    carry/borrow out of the last stage (tick[N-1])
//   alarm     out  1    registered one-cycle alarm pulse
module cascade_counter #(
  parameter int              N  = 3,
  parameter int              DW = 6,
  parameter longint unsigned M [N] = '{64'd60, 64'd60, 64'd24}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [N*DW-1:0] load_val,
  input  logic            alarm_en,
  input  logic [N*DW-1:0] alarm_val,
  output logic [N*DW-1:0] cnt,
  output logic [N-1:0]    tick,
  output logic            co,
  output logic            alarm
);

  localparam logic [DW-1:0] ONE_C  = DW'(32'd1);
  localparam logic [DW-1:0] ZERO_C = {DW{1'b0}};

  logic [N*DW-1:0] cnt_q, cnt_d;
  logic            alarm_q, alarm_d;

  // Per-stage working values, rewritten for every stage inside the loop.
  logic            chain_s;
  logic [DW-1:0]   field_s;
  logic [DW-1:0]   max_s;
  logic [DW-1:0]   term_s;
  logic [DW-1:0]   lfield_s;

  // Next-state and tick generation for every stage.
  // chain_s carries the stage enable e_i down the cascade.
  always_comb begin
    cnt_d    = cnt_q;
    tick     = {N{1'b0}};
    chain_s  = en;
    field_s  = ZERO_C;
    max_s    = ZERO_C;
    term_s   = ZERO_C;
    lfield_s = ZERO_C;
    for (int i = 0; i < N; i++) begin
      field_s  = cnt_q[i*DW +: DW];
      max_s    = DW'(M[i] - 64'd1);
      lfield_s = load_val[i*DW +: DW];
      if (up) begin
        term_s = max_s;
      end else begin
        term_s = ZERO_C;
      end

      if (load) begin
        // Out-of-range load fields saturate so cnt never leaves 0..M[i]-1.
        if (lfield_s > max_s) begin
          cnt_d[i*DW +: DW] = max_s;
        end else begin
          cnt_d[i*DW +: DW] = lfield_s;
        end
      end else if (chain_s) begin
        if (field_s == term_s) begin
          tick[i] = 1'b1;
          if (up) begin
            cnt_d[i*DW +: DW] = ZERO_C;
          end else begin
            cnt_d[i*DW +: DW] = max_s;
          end
        end else begin
          if (up) begin
            cnt_d[i*DW +: DW] = field_s + ONE_C;
          end else begin
            cnt_d[i*DW +: DW] = field_s - ONE_C;
          end
        end
      end else begin
        cnt_d[i*DW +: DW] = field_s;
      end

      chain_s = chain_s & (field_s == term_s);
    end
  end

  // Alarm fires only when cnt is written this cycle and lands on alarm_val;
  // stage 0 always moves when en is high, so load|en means "a field changes".
  always_comb begin
    alarm_d = alarm_en & (load | en) & (cnt_d == alarm_val);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= {(N*DW){1'b0}};
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign cnt   = cnt_q;
  assign alarm = alarm_q;
  assign co    = tick[N-1];

endmodule

// File: tb/tb_cascade_counter.sv
// Testbench for cascade_counter with default parameters (60/60/24, DW=6).
// Table vectors are driven on the falling edge. tick/co are sampled just
// before the rising edge; cnt/alarm are sampled 1ns after it.
module tb_cascade_counter;

  localparam int N  = 3;
  localparam int DW = 6;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         rst, en, up, load, alarm_en;
  logic [W-1:0] load_val, alarm_val;
  logic [W-1:0] cnt;
  logic [N-1:0] tick;
  logic         co, alarm;

  int n_checks = 0;
  int n_pass   = 0;

  cascade_counter dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .alarm_en(alarm_en), .alarm_val(alarm_val),
    .cnt(cnt), .tick(tick), .co(co), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rst, en, up, load;
    logic [W-1:0] lv;
    bit           aen;
    logic [W-1:0] av;
    logic [W-1:0] ecnt;
    logic [N-1:0] etick;
    bit           ealarm;
  } vec_t;

  vec_t tbl[$];

  // Build a {hr,min,sec} value in the stage field layout.
  function automatic logic [W-1:0] L(input int h, input int m, input int s);
    logic [31:0] hv, mv, sv;
    hv = h; mv = m; sv = s;
    return {hv[5:0], mv[5:0], sv[5:0]};
  endfunction

  function automatic vec_t mk(input bit r, input bit e, input bit u, input bit l,
                              input logic [W-1:0] lv, input bit ae,
                              input logic [W-1:0] av, input logic [W-1:0] ec,
                              input logic [N-1:0] et, input bit ea);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv; v.aen = ae;
    v.av = av; v.ecnt = ec; v.etick = et; v.ealarm = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick1_n, alarm_n, alarm_at, bad;
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; alarm_en = 1'b0;
    load_val = '0; alarm_val = '0;

    //          rst en up ld  load_val     aen alarm_val   exp cnt       tick    alarm
    tbl.push_back(mk(1, 0, 1, 0, L(0,0,0),    0, L(0,0,0),  L(0,0,0),    3'b000, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 1, 0, L(0,0,0),  0, L(0,0,0),  L(0,0,0),    3'b000, 0));
    tbl.push_back(mk(0, 0, 1, 1, L(23,59,59), 0, L(0,0,0),  L(23,59,59), 3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    0, L(0,0,0),  L(0,0,0),    3'b111, 0));
    tbl.push_back(mk(0, 1, 0, 0, L(0,0,0),    0, L(0,0,0),  L(23,59,59), 3'b111, 0));
    // Load beats a would-be full wrap; ticks are suppressed.
    tbl.push_back(mk(0, 1, 1, 1, L(0,0,58),   0, L(0,0,0),  L(0,0,58),   3'b000, 0));
    // Saturation: the minute value 70 does not fit in 6 bits, so 62 is used instead.
    tbl.push_back(mk(0, 0, 1, 1, L(30,62,5),  0, L(0,0,0),  L(23,59,5),  3'b000, 0));
    tbl.push_back(mk(0, 0, 1, 1, L(1,60,60),  0, L(0,0,0),  L(1,59,59),  3'b000, 0));
    tbl.push_back(mk(1, 1, 1, 1, L(5,5,5),    0, L(0,0,0),  L(0,0,0),    3'b000, 0));
    // Direction flip sequence starting from {0,0,5}.
    tbl.push_back(mk(0, 0, 1, 1, L(0,0,5),    0, L(0,0,0),  L(0,0,5),    3'b000, 0));
    for (int k = 4; k >= 0; k--)
      tbl.push_back(mk(0, 1, 0, 0, L(0,0,0),  0, L(0,0,0),  L(0,0,k),    3'b000, 0));
    tbl.push_back(mk(0, 1, 0, 0, L(0,0,0),    0, L(0,0,0),  L(23,59,59), 3'b111, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    0, L(0,0,0),  L(0,0,0),    3'b111, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    0, L(0,0,0),  L(0,0,1),    3'b000, 0));
    tbl.push_back(mk(0, 1, 0, 0, L(0,0,0),    0, L(0,0,0),  L(0,0,0),    3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    0, L(0,0,0),  L(0,0,1),    3'b000, 0));
    // Alarm behaviour.
    tbl.push_back(mk(0, 0, 1, 1, L(0,0,58),   1, L(0,1,0),  L(0,0,58),   3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    1, L(0,1,0),  L(0,0,59),   3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    1, L(0,1,0),  L(0,1,0),    3'b001, 1));
    tbl.push_back(mk(0, 0, 1, 0, L(0,0,0),    1, L(0,1,0),  L(0,1,0),    3'b000, 0));
    tbl.push_back(mk(0, 0, 1, 1, L(0,1,0),    1, L(0,1,0),  L(0,1,0),    3'b000, 1));
    tbl.push_back(mk(0, 0, 1, 1, L(0,0,59),   0, L(0,1,0),  L(0,0,59),   3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    0, L(0,1,0),  L(0,1,0),    3'b001, 0));
    tbl.push_back(mk(0, 1, 0, 0, L(0,0,0),    1, L(0,0,59), L(0,0,59),   3'b001, 1));
    tbl.push_back(mk(0, 0, 0, 0, L(0,0,0),    1, L(0,0,59), L(0,0,59),   3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 0, L(0,0,0),    1, L(0,0,59), L(0,1,0),    3'b001, 0));

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; en = tbl[k].en; up = tbl[k].up; load = tbl[k].load;
      load_val = tbl[k].lv; alarm_en = tbl[k].aen; alarm_val = tbl[k].av;
      #2;
      check($sformatf("v%0d tick", k), 64'(tick), 64'(tbl[k].etick));
      check($sformatf("v%0d co", k), 64'(co), 64'(tbl[k].etick[N-1]));
      @(posedge clk); #1;
      check($sformatf("v%0d cnt", k), 64'(cnt), 64'(tbl[k].ecnt));
      check($sformatf("v%0d alarm", k), 64'(alarm), 64'(tbl[k].ealarm));
    end

    // Long up-count from reset: 3600 steps against an arithmetic time model.
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0; alarm_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1; alarm_en = 1'b1; alarm_val = L(0,1,0);
    tick1_n = 0; alarm_n = 0; alarm_at = -1; bad = 0;
    for (int t = 1; t <= 3600; t++) begin
      #2;
      if (tick[1]) tick1_n++;
      if (t == 60) check("run tick0@60", 64'(tick[0]), 64'd1);
      @(posedge clk); #1;
      if (cnt !== L((t / 3600) % 24, (t / 60) % 60, t % 60)) bad++;
      if (alarm) begin alarm_n++; alarm_at = t; end
      if (t == 59)   check("run cnt@59", 64'(cnt), 64'(L(0,0,59)));
      if (t == 60)   check("run cnt@60", 64'(cnt), 64'(L(0,1,0)));
      if (t == 3600) check("run cnt@3600", 64'(cnt), 64'(L(1,0,0)));
      @(negedge clk);
    end
    check("run model mismatches", 64'(bad), 64'd0);
    check("run tick1 pulses", 64'(tick1_n), 64'd1);
    check("run alarm pulses", 64'(alarm_n), 64'd1);
    check("run alarm cycle", 64'(alarm_at), 64'd60);

    // Idle with en=0: count holds and no alarm appears.
    en = 1'b0; alarm_n = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      if (alarm) alarm_n++;
    end
    check("idle alarm pulses", 64'(alarm_n), 64'd0);
    check("idle cnt hold", 64'(cnt), 64'(L(1,0,0)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
